// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with IF/ID register; one-outstanding req/gnt/rvalid fetch port
// and a 1-entry skid buffer that catches a word returning while decode is stalled.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0]     NOP      = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_stallf,
   input  logic            i_stalld,
   input  logic            i_flushd,
   input  logic            i_pc_src_e,
   input  logic [XLEN-1:0] i_pc_target_e,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [31:0]     i_imem_rdata,
   output logic [31:0]     o_instr_d,
   output logic [XLEN-1:0] o_pc_d,
   output logic [XLEN-1:0] o_pc_plus4_d,
   output logic            o_valid_d
);
   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
   state_t          r_state, w_state_nxt;
   logic [XLEN-1:0] r_pcf, w_pcf_nxt, w_target;
   logic            r_buf_valid;
   logic [31:0]     r_buf_word;
   logic [XLEN-1:0] r_buf_pc;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_pcd, r_pc4;
   logic            r_valid;
   logic            w_req, w_deliver;

   assign w_target    = i_pc_target_e & ~XLEN'(3);
   assign w_req       = rst_n & (r_state == S_REQ) & ~i_stallf & ~r_buf_valid & ~i_pc_src_e;
   assign w_deliver   = (r_state == S_WAIT) & i_imem_rvalid & ~i_pc_src_e;
   assign o_imem_req  = w_req;
   assign o_imem_addr = r_pcf;
   assign o_instr_d    = r_instr;
   assign o_pc_d       = r_pcd;
   assign o_pc_plus4_d = r_pc4;
   assign o_valid_d    = r_valid;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_REQ:   w_state_nxt = (w_req & i_imem_gnt) ? S_WAIT : S_REQ;
         S_WAIT:  w_state_nxt = i_imem_rvalid ? S_REQ : i_pc_src_e ? S_DROP : S_WAIT;
         S_DROP:  w_state_nxt = i_imem_rvalid ? S_REQ : S_DROP;
         default: w_state_nxt = S_REQ;
      endcase
      w_pcf_nxt = i_pc_src_e ? w_target : w_deliver ? r_pcf + XLEN'(4) : r_pcf;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_REQ;
         r_pcf       <= RESET_PC;
         r_buf_valid <= 1'b0;
         r_instr     <= NOP;
         r_pcd       <= '0;
         r_pc4       <= '0;
         r_valid     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pcf   <= w_pcf_nxt;
         if (i_flushd) begin
            r_instr     <= NOP;
            r_valid     <= 1'b0;
            r_buf_valid <= 1'b0;
         end else if (i_stalld) begin
            // requests are blocked while the buffer is full, so it is always free here
            if (w_deliver) begin
               r_buf_valid <= 1'b1;
               r_buf_word  <= i_imem_rdata;
               r_buf_pc    <= r_pcf;
            end
         end else if (r_buf_valid) begin
            r_instr     <= r_buf_word;
            r_pcd       <= r_buf_pc;
            r_pc4       <= r_buf_pc + XLEN'(4);
            r_valid     <= 1'b1;
            r_buf_valid <= 1'b0;
         end else if (w_deliver) begin
            r_instr <= i_imem_rdata;
            r_pcd   <= r_pcf;
            r_pc4   <= r_pcf + XLEN'(4);
            r_valid <= 1'b1;
         end else begin
            r_instr <= NOP;
            r_valid <= 1'b0;
         end
      end
   end
endmodule
